// File: rtl/pw_act_packer.sv
// pw_act_packer
// Packs a stream of AW-bit activations into CH-lane words for a downstream
// pointwise layer. A word closes when lane CH-1 fills or when s_last arrives.
// The closed word is presented with a one-cycle valid strobe and held until
// the next word. An optional GAP of idle cycles follows each word.
module pw_act_packer #(
    parameter int CH  = 8,
    parameter int AW  = 8,
    parameter int GAP = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             soft_clr,
    input  logic             s_valid,
    input  logic [AW-1:0]    s_data,
    input  logic             s_last,
    output logic             s_ready,
    output logic             valid,
    output logic [CH*AW-1:0] input_act,
    output logic [15:0]      pkt_count,
    output logic             short_pkt
);

    localparam int LW = (CH > 1) ? $clog2(CH) : 1;

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]       state;
    logic [7:0]       gap_cnt;
    logic [LW-1:0]    lane;
    logic [CH*AW-1:0] partial;
    logic [CH*AW-1:0] merged;
    logic             alive;

    logic accept;
    logic last_lane;
    logic close;

    // alive holds s_ready low during reset and raises it on the first edge after.
    assign s_ready   = alive && (state == ST_FILL);
    assign accept    = s_valid && s_ready && !soft_clr;
    assign last_lane = (lane == LW'(CH - 1));
    assign close     = accept && (s_last || last_lane);

    // Partial word with the incoming byte dropped into the current lane.
    always_comb begin
        // NOTE: default assignment first so no path leaves merged unassigned (no latch).
        merged = partial;
        for (int k = 0; k < CH; k++) begin
            if (lane == LW'(k)) begin
                merged[k*AW +: AW] = s_data;
            end
        end
    end

    // Lane pointer, partial word, output word, strobe and status.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: the partial word is reset so a word cut short by reset never leaks stale lanes.
            alive     <= 1'b0;
            valid     <= 1'b0;
            input_act <= '0;
            pkt_count <= '0;
            short_pkt <= 1'b0;
            lane      <= '0;
            partial   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            alive <= 1'b1;
            valid <= close;
            if (soft_clr) begin
                lane      <= '0;
                partial   <= '0;
                pkt_count <= '0;
                short_pkt <= 1'b0;
            end else if (accept) begin
                if (close) begin
                    input_act <= merged;
                    partial   <= '0;
                    lane      <= '0;
                    pkt_count <= pkt_count + 16'd1;
                    if (!last_lane) begin
                        short_pkt <= 1'b1;
                    end
                end else begin
                    partial <= merged;
                    lane    <= lane + LW'(1);
                end
            end
        end
    end

    // FILL/HOLD sequencing: after a word, HOLD keeps s_ready low for GAP cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_FILL;
            gap_cnt <= '0;
        end else if (soft_clr) begin
            state   <= ST_FILL;
            gap_cnt <= '0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (close && (GAP > 0)) begin
                        state   <= ST_HOLD;
                        gap_cnt <= 8'(GAP);
                    end
                end
                ST_HOLD: begin
                    if (gap_cnt <= 8'd1) begin
                        state   <= ST_FILL;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: begin
                    state   <= ST_FILL;
                    gap_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/pw_act_packer.md
PW_ACT_PACKER -- requirements
Module: pw_act_packer

Interface
REQ-001 Parameter CH, default 8: activation lanes per packed word.
REQ-002 Parameter AW, default 8: bits per activation lane.
REQ-003 Parameter GAP, default 0: minimum idle cycles between consecutive valid pulses (0..255).
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 soft_clr  input  1  synchronous clear of packing state and status.
REQ-007 s_valid  input  1  upstream byte valid.
REQ-008 s_data  input  AW  upstream activation.
REQ-009 s_last  input  1  the current byte is the final byte of its pixel and closes the word.
REQ-010 s_ready  output  1  the block can accept a byte this cycle.
REQ-011 valid  output  1  one-cycle strobe; input_act is valid for the downstream pointwise layer.
REQ-012 input_act  output  CH*AW  packed word; lane k occupies bits [k*AW+AW-1 : k*AW].
REQ-013 pkt_count  output  16  count of emitted words.
REQ-014 short_pkt  output  1  sticky flag: a word closed early by s_last.

Function
REQ-015 A byte is accepted only when s_valid=1 and s_ready=1 in the same cycle.
REQ-016 Accepted bytes fill lanes in order 0,1,...,CH-1, tracked by a lane pointer that is 0 at the start of each word.
REQ-017 The word closes on accepting lane CH-1, or on accepting any byte with s_last=1, whichever comes first.
REQ-018 Lanes not written before an early close read 0 in the emitted word.
REQ-019 An early close (s_last on a lane below CH-1) sets short_pkt, which stays set until reset or soft_clr.
REQ-020 s_last on lane CH-1 is a normal close and does not set short_pkt.
REQ-021 valid is 1 for exactly one cycle, in the cycle after the closing byte is accepted.
REQ-022 input_act carries the closed word in the valid cycle and holds it stable until the next valid pulse.
REQ-023 The downstream has no backpressure; valid is never stalled or repeated.
REQ-024 FSM has two states, FILL and HOLD.
REQ-025 FILL: s_ready=1.
REQ-026 HOLD: s_ready=0; a down-counter loaded with GAP decrements once per cycle.
REQ-027 On word close with GAP=0: the FSM stays in FILL and the next byte can be accepted in the valid cycle, giving one byte per cycle sustained.
REQ-028 On word close with GAP>0: the FSM enters HOLD in the valid cycle and returns to FILL after GAP cycles in HOLD.
REQ-029 pkt_count increments in the valid cycle and wraps 0xFFFF->0x0000.
REQ-030 soft_clr=1 has priority over acceptance in the same cycle: the byte is dropped, valid is not generated, and the following are cleared: lane pointer, partial word, pkt_count, short_pkt, and FSM (to FILL).
REQ-031 soft_clr does not clear input_act.
REQ-032 soft_clr does not cancel a valid strobe already registered for the current cycle.
REQ-033 s_data/s_last are ignored when s_valid=0 or s_ready=0.

Reset
REQ-034 While rstn=0, all outputs are driven as follows, independent of clk: valid=0, input_act=0, pkt_count=0, short_pkt=0, s_ready=0.
REQ-035 While rstn=0, internally: FSM=FILL, lane pointer=0, gap counter=0.
REQ-036 s_ready rises to 1 on the first clk edge after rstn deasserts.
REQ-037 Reset mid-word discards the partial word and emits no valid.

Verification
REQ-038 CH=8, GAP=0: stream bytes 0x01..0x10 on consecutive cycles, no s_last -> two valid pulses 8 cycles apart; input_act=0x0807060504030201 then 0x100F0E0D0C0B0A09; pkt_count=2; short_pkt=0.
REQ-039 CH=8: 3 bytes 0xAA,0xBB,0xCC with s_last on 0xCC -> one valid with input_act=0x0000000000CCBBAA; short_pkt=1.
REQ-040 CH=8, GAP=3: 16 bytes offered continuously -> s_ready=0 for exactly 3 cycles after each valid; valid pulses 11 cycles apart.
REQ-041 soft_clr asserted on the same cycle as lane-5 acceptance -> no valid; next 8 bytes produce one word starting at lane 0; pkt_count restarts at 1.
REQ-042 Preload pkt_count to 0xFFFF (emit 65535 words), emit one more -> pkt_count=0x0000.
REQ-043 rstn pulsed low after 4 bytes accepted -> all outputs 0 immediately; no valid afterwards until 8 new bytes are accepted.
